// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the EX operand muxes, the pipelined ALU
// and the EX/MEM register.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [3:0]       alu_command;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       statusRegister;

  modport master (
    output in_valid, alu_in1, alu_in2, alu_command, set_flags, out_ready,
    input  in_ready, out_valid, alu_out, statusRegister
  );

  modport slave (
    input  in_valid, alu_in1, alu_in2, alu_command, set_flags, out_ready,
    output in_ready, out_valid, alu_out, statusRegister
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: valid/ready on both sides, {Z,C,N,V} status register
// feeding ADC/SBC carry, and a WIDTH-cycle shift-add unsigned multiplier.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB   = WIDTH - 1;
  localparam int FZ = 3, FC = 2, FN = 1, FV = 0;

  localparam logic [3:0] OP_MOV = 4'b0001, OP_MVN = 4'b1001, OP_ADD = 4'b0010,
                         OP_ADC = 4'b0011, OP_SUB = 4'b0100, OP_SBC = 4'b0101,
                         OP_AND = 4'b0110, OP_ORR = 4'b0111, OP_EOR = 4'b1000,
                         OP_CMP = 4'b1100, OP_TST = 4'b1110, OP_ADR = 4'b1010,
                         OP_MUL = 4'b1011;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_HOLD = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic [3:0]         flags_q, flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               mul_s_q, mul_s_d;

  logic [WIDTH-1:0]   a, b, acc_step, op_res;
  logic [WIDTH:0]     sum_ext, dif_ext;
  logic               cin, bin, op_c, op_v, op_wr_zn, op_wr_cv;
  logic               slot_free, in_ready, accept, mul_last;

  assign a         = bus.alu_in1;
  assign b         = bus.alu_in2;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = (state_q == ST_IDLE) && slot_free;
  assign accept    = bus.in_valid && in_ready;
  assign mul_last  = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_step  = mplier_q[0] ? acc_q + mcand_q : acc_q;

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.alu_out        = alu_out_q;
  assign bus.statusRegister = flags_q;

  function automatic logic [3:0] merge_flags(input logic [3:0] old, input logic [WIDTH-1:0] res,
                                             input logic wr_zn, input logic wr_cv,
                                             input logic c, input logic v);
    merge_flags = {wr_zn ? (res == '0) : old[FZ], wr_cv ? c : old[FC],
                   wr_zn ? res[MSB] : old[FN], wr_cv ? v : old[FV]};
  endfunction

  // The extra top bit of each sum is the carry-out; for subtraction it is the borrow.
  always_comb begin
    cin     = (bus.alu_command == OP_ADC) && flags_q[FC];
    bin     = (bus.alu_command == OP_SBC) && !flags_q[FC];
    sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    dif_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  end

  always_comb begin
    op_res   = '0;
    op_c     = flags_q[FC];
    op_v     = flags_q[FV];
    op_wr_zn = 1'b0;
    op_wr_cv = 1'b0;
    case (bus.alu_command)
      OP_MOV: begin op_res = b;  op_wr_zn = bus.set_flags; end
      OP_MVN: begin op_res = ~b; op_wr_zn = bus.set_flags; end
      OP_ADD, OP_ADC, OP_ADR: begin
        op_res   = sum_ext[MSB:0];
        op_c     = sum_ext[WIDTH];
        op_v     = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
        op_wr_zn = bus.set_flags && (bus.alu_command != OP_ADR);
        op_wr_cv = op_wr_zn;
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        op_res   = dif_ext[MSB:0];
        op_c     = !dif_ext[WIDTH];
        op_v     = (a[MSB] != b[MSB]) && (dif_ext[MSB] != a[MSB]);
        op_wr_zn = bus.set_flags || (bus.alu_command == OP_CMP);
        op_wr_cv = op_wr_zn;
      end
      OP_AND, OP_TST: begin
        op_res   = a & b;
        op_wr_zn = bus.set_flags || (bus.alu_command == OP_TST);
      end
      OP_ORR: begin op_res = a | b; op_wr_zn = bus.set_flags; end
      OP_EOR: begin op_res = a ^ b; op_wr_zn = bus.set_flags; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && bus.alu_command == OP_MUL) state_d = ST_MUL;
      ST_MUL:  if (mul_last) state_d = slot_free ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (slot_free) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A finished product waits in acc_q (HOLD) until the output slot is free.
  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    mul_s_d     = mul_s_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.alu_command == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            mul_s_d  = bus.set_flags;
          end else begin
            alu_out_d   = op_res;
            out_valid_d = 1'b1;
            flags_d     = merge_flags(flags_q, op_res, op_wr_zn, op_wr_cv, op_c, op_v);
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[MSB-1:0], 1'b0};
        mplier_d = {1'b0, mplier_q[MSB:1]};
        cnt_d    = cnt_q + 1'b1;
        if (mul_last) begin
          cnt_d = '0;
          if (slot_free) begin
            alu_out_d   = acc_step;
            out_valid_d = 1'b1;
            flags_d     = merge_flags(flags_q, acc_step, mul_s_q, 1'b0, 1'b0, 1'b0);
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          alu_out_d   = acc_q;
          out_valid_d = 1'b1;
          flags_d     = merge_flags(flags_q, acc_q, mul_s_q, 1'b0, 1'b0, 1'b0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      mul_s_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      mul_s_q     <= mul_s_d;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios, then randomized traffic with output
// backpressure, scored against a queue-based arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 32;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    bit          is_mul;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int         n_checks;
  int         n_errors;
  int         n_txn;
  exp_t       exp_q[$];
  logic [3:0] m_flags;
  bit         mul_pending;
  bit         lat_pending;
  bit         mon_en;
  bit         rand_rdy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: flags {Z,C,N,V}; carry from wide arithmetic, borrow from compare.
  task automatic model_accept(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                              input logic s);
    logic [63:0] t;
    logic [31:0] r;
    logic        c, v, wzn, wcv, bw;
    exp_t        e;
    c = m_flags[2]; v = m_flags[0]; wzn = 1'b0; wcv = 1'b0; r = '0; t = '0;
    case (cmd)
      4'h1: begin r = b;  wzn = s; end
      4'h9: begin r = ~b; wzn = s; end
      4'h2, 4'h3, 4'hA: begin
        t   = 64'(a) + 64'(b) + ((cmd == 4'h3 && m_flags[2]) ? 64'd1 : 64'd0);
        r   = t[31:0];
        c   = (t > 64'hFFFF_FFFF);
        v   = (a[31] == b[31]) && (r[31] != a[31]);
        wzn = s && (cmd != 4'hA);
        wcv = wzn;
      end
      4'h4, 4'h5, 4'hC: begin
        bw  = (cmd == 4'h5) && !m_flags[2];
        r   = a - b - 32'(bw);
        c   = (64'(a) >= 64'(b) + 64'(bw));
        v   = (a[31] != b[31]) && (r[31] != a[31]);
        wzn = s || (cmd == 4'hC);
        wcv = wzn;
      end
      4'h6, 4'hE: begin r = a & b; wzn = s || (cmd == 4'hE); end
      4'h7: begin r = a | b; wzn = s; end
      4'h8: begin r = a ^ b; wzn = s; end
      4'hB: begin t = 64'(a) * 64'(b); r = t[31:0]; wzn = s; end
      default: r = '0;
    endcase
    if (wzn) begin m_flags[3] = (r == 0); m_flags[1] = r[31]; end
    if (wcv) begin m_flags[2] = c; m_flags[0] = v; end
    e.cmd = cmd; e.a = a; e.b = b; e.res = r; e.flg = m_flags; e.is_mul = (cmd == 4'hB);
    exp_q.push_back(e);
    if (cmd == 4'hB) mul_pending = 1'b1;
    else             lat_pending = 1'b1;
  endtask

  task automatic monitor();
    exp_t h;
    logic exp_rdy;
    if (!mon_en) begin
      exp_q.delete();
      m_flags = '0; mul_pending = 1'b0; lat_pending = 1'b0;
      return;
    end
    if (lat_pending) check_val("latency1_valid", 32'(bus.out_valid), 1);
    lat_pending = 1'b0;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 32'(bus.out_valid), 0);
      end else begin
        h = exp_q[0];
        if (h.is_mul) mul_pending = 1'b0;
        check_val("alu_out", bus.alu_out, h.res);
        check_val("status", 32'(bus.statusRegister), 32'(h.flg));
      end
    end
    exp_rdy = !mul_pending && (!bus.out_valid || bus.out_ready);
    check_val("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
      h = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: cmd=%h a=%h b=%h -> out=%h flags=%b", n_txn, h.cmd, h.a, h.b, h.res, h.flg);
    end
    if (bus.in_valid && bus.in_ready)
      model_accept(bus.alu_command, bus.alu_in1, bus.alu_in2, bus.set_flags);
  endtask

  task automatic nedge();
    @(negedge clk);
    monitor();
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents an op and holds it until accepted; returns just after the accept edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    bit acc;
    int waited;
    bus.in_valid = 1'b1; bus.alu_command = cmd; bus.alu_in1 = a; bus.alu_in2 = b;
    bus.set_flags = s;
    acc = 1'b0; waited = 0;
    while (!acc) begin
      nedge();
      if (bus.in_ready) begin
        acc = 1'b1;
      end else if (waited >= 300) begin
        check_val("issue_timeout", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        acc = 1'b1;
      end
      pedge();
      waited++;
    end
  endtask

  // Entered just after a rising edge; leaves reset released just after a rising edge.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    mon_en = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_val("rst_alu_out", bus.alu_out, 0);
    check_val("rst_status", 32'(bus.statusRegister), 0);
    check_val("rst_out_valid", 32'(bus.out_valid), 0);
    nedge(); pedge(); nedge(); pedge();
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: rand_opnd = 32'h0000_0000;
      1: rand_opnd = 32'hFFFF_FFFF;
      2: rand_opnd = 32'h7FFF_FFFF;
      3: rand_opnd = 32'h8000_0000;
      4: rand_opnd = 32'($urandom_range(0, 15));
      default: rand_opnd = $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_cmd();
    logic [3:0] c;
    c = 4'($urandom_range(0, 15));
    if (c == 4'hB && $urandom_range(0, 3) != 0) c = 4'h3;
    rand_cmd = c;
  endfunction

  initial begin
    int low_cnt;
    int valid_cnt;
    n_checks = 0; n_errors = 0; n_txn = 0;
    m_flags = '0; mul_pending = 1'b0; lat_pending = 1'b0; mon_en = 1'b0; rand_rdy = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.alu_in1 = '0; bus.alu_in2 = '0; bus.alu_command = '0;
    bus.set_flags = 1'b0; bus.out_ready = 1'b1;
    pedge();
    do_reset();

    // Signed overflow into the sign bit.
    issue(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    bus.in_valid = 1'b0;
    nedge();
    check_val("add_ovf_out", bus.alu_out, 32'h8000_0000);
    check_val("add_ovf_flags", 32'(bus.statusRegister), 32'(4'b0011));
    pedge();

    // Carry produced by ADD is consumed by ADC issued on the very next cycle.
    issue(4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    bus.alu_command = 4'h3; bus.alu_in1 = 32'd5; bus.alu_in2 = 32'd0; bus.set_flags = 1'b0;
    nedge();
    check_val("add_carry_out", bus.alu_out, 32'h0);
    check_val("add_carry_flags", 32'(bus.statusRegister), 32'(4'b1100));
    check_val("adc_b2b_ready", 32'(bus.in_ready), 1);
    pedge();
    bus.in_valid = 1'b0;
    nedge();
    check_val("adc_out", bus.alu_out, 32'd6);
    pedge();

    // SUB without S leaves flags; CMP always writes them.
    do_reset();
    issue(4'h4, 32'd3, 32'd5, 1'b0);
    bus.alu_command = 4'hC; bus.alu_in1 = 32'd5; bus.alu_in2 = 32'd5; bus.set_flags = 1'b0;
    nedge();
    check_val("sub_out", bus.alu_out, 32'hFFFF_FFFE);
    check_val("sub_noS_flags", 32'(bus.statusRegister), 0);
    pedge();
    bus.in_valid = 1'b0;
    nedge();
    check_val("cmp_out", bus.alu_out, 32'h0);
    check_val("cmp_flags", 32'(bus.statusRegister), 32'(4'b1100));
    pedge();

    // Multiply stalls issue for WIDTH cycles; a waiting ADD is held off.
    issue(4'hB, 32'h0001_0003, 32'd7, 1'b0);
    bus.alu_command = 4'h2; bus.alu_in1 = 32'd2; bus.alu_in2 = 32'd3;
    low_cnt = 0;
    repeat (W) begin
      nedge();
      if (!bus.in_ready) low_cnt++;
      pedge();
    end
    check_val("mul_busy_cycles", low_cnt, W);
    nedge();
    check_val("mul_valid", 32'(bus.out_valid), 1);
    check_val("mul_out", bus.alu_out, 32'h0007_0015);
    check_val("mul_done_ready", 32'(bus.in_ready), 1);
    pedge();
    bus.in_valid = 1'b0;

    // Output backpressure holds the AND result and blocks issue.
    issue(4'h6, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    bus.out_ready = 1'b0;
    bus.alu_command = 4'h7; bus.alu_in1 = 32'h0000_00F0; bus.alu_in2 = 32'h0000_000F;
    repeat (3) begin
      nedge();
      check_val("hold_valid", 32'(bus.out_valid), 1);
      check_val("hold_out", bus.alu_out, 32'h00F0_1234);
      check_val("hold_ready", 32'(bus.in_ready), 0);
      pedge();
    end
    bus.out_ready = 1'b1;
    nedge();
    check_val("release_ready", 32'(bus.in_ready), 1);
    pedge();
    bus.in_valid = 1'b0;
    nedge();
    check_val("orr_after_release", bus.alu_out, 32'h0000_00FF);
    pedge();

    // Reset in the middle of a multiply discards it.
    issue(4'h7, 32'h8000_0000, 32'h0, 1'b1);
    issue(4'hB, 32'h0000_1234, 32'h0000_5678, 1'b1);
    bus.in_valid = 1'b0;
    repeat (9) begin nedge(); pedge(); end
    do_reset();
    valid_cnt = 0;
    repeat (W + 5) begin
      nedge();
      if (bus.out_valid) valid_cnt++;
      pedge();
    end
    check_val("no_mul_after_rst", valid_cnt, 0);
    issue(4'h2, 32'd2, 32'd2, 1'b0);
    bus.in_valid = 1'b0;
    nedge();
    check_val("add_after_rst", bus.alu_out, 32'd4);
    pedge();

    // Randomized traffic with random output backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        nedge();
        pedge();
      end
      issue(rand_cmd(), rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      nedge();
      pedge();
    end
    check_val("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the execute-stage ALU; sits in EX, between operand/forwarding muxes and EX/MEM register.
- Adds valid/ready handshake on both sides and an internal status register {Z,C,N,V} that feeds carry into ADC/SBC.
- Adds a multi-cycle unsigned MUL that stalls issue.

Parameters:
WIDTH, 32, datapath width in bits (>=8)
CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  operation accepted when in_valid && in_ready
alu_in1  in  WIDTH  operand A
alu_in2  in  WIDTH  operand B
alu_command  in  4  operation code
set_flags  in  1  S bit: update status register for this operation
out_valid  out  1  result available
out_ready  in  1  consumer takes result when out_valid && out_ready
alu_out  out  WIDTH  registered result
statusRegister  out  4  {Z,C,N,V}, registered

Behaviour:
- Reset (rst_n=0, asynchronous, any state, including mid-MUL): alu_out=0, statusRegister=0, out_valid=0, FSM=IDLE, counter=0, multiply accumulators=0. Any in-flight MUL is discarded.
- States: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; in_ready never depends on in_valid.
- Single-cycle ops, accepted in IDLE:
  - Result computed from operands and the current flags register.
  - Result is registered on the accept edge; out_valid=1 on the next cycle (latency 1).
  - Back-to-back issue at 1 op/cycle when out_ready=1.
- Opcodes (C = carry / no-borrow):
  - 0001 MOV: out=in2.
  - 1001 MVN: out=~in2.
  - 0010 ADD: {C,out}=in1+in2.
  - 0011 ADC: {C,out}=in1+in2+C_flag.
  - 0100 SUB: out=in1-in2; C=1 iff in1>=in2 unsigned.
  - 0101 SBC: out=in1-in2-!C_flag; C=1 iff in1 >= in2+!C_flag unsigned.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - 1100 CMP: as SUB, flags always updated regardless of set_flags.
  - 1110 TST: as AND, flags always updated.
  - 1010 address add: in1+in2, never updates flags.
  - 1011 MUL: low WIDTH bits of unsigned in1*in2.
  - Any other code: out=0, flags unchanged.
- V rules:
  - Add: V = (in1[MSB]==in2[MSB]) && (out[MSB]!=in1[MSB]).
  - Subtract: V = (in1[MSB]!=in2[MSB]) && (out[MSB]!=in1[MSB]).
  - Logic/MOV/MVN/MUL leave C and V unchanged.
  - Z = (out==0), N = out[MSB] for every flag-updating op.
- Flag update timing:
  - Flags are written on the same edge as alu_out.
  - An ADC/SBC accepted on the following cycle sees the new C.
  - No flag write when set_flags=0, except CMP/TST.
- Multiply:
  - Accepting 1011 moves IDLE->MUL and latches the operands.
  - Shift-add, one bit per cycle, exactly WIDTH cycles with in_ready=0.
  - On completion: alu_out and Z/N (if set_flags) are written, out_valid=1, state goes to IDLE.
  - Total latency is WIDTH+1 cycles from accept to out_valid.
- Output hold:
  - When out_valid=1 and out_ready=0, alu_out/out_valid stay stable and in_ready=0.
  - If a MUL completes while the output is occupied and not taken, the FSM enters HOLD and keeps the product internal.
  - HOLD moves to IDLE, presenting the product, on the first cycle the output slot frees.
- out_valid clears only when out_ready=1 and no new result is written that cycle. Simultaneous take-and-accept keeps out_valid=1 with the new data.
- in_valid with in_ready=0: the op is neither consumed nor affects state. The producer must hold its inputs.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 with S=1 -> out=0x80000000, flags Z0 C0 N1 V1 one cycle after accept.
- ADD 0xFFFFFFFF+1 with S=1, then ADC 5+0 next cycle -> first out=0, Z=1 C=1; ADC out=6.
- SUB 3-5 with S=0, then CMP 5,5 -> SUB out=0xFFFFFFFE with flags unchanged (0); CMP sets Z=1 C=1.
- MUL 0x0001_0003 * 7 -> in_ready low for 32 cycles; out=0x0007_0015 at cycle 33; ops issued meanwhile are not accepted.
- out_ready=0 for 3 cycles after an AND result -> alu_out stable, in_ready=0; releasing it accepts the next op the same cycle.
- rst_n low at MUL cycle 10 -> all outputs 0 immediately; after release the first ADD 2+2 gives 4 with latency 1.
